burst_mem_model: RTL and testbench

Parametrised memory-side responder for the burst_ctrl mem_* interface, used by video and CPU benches in place of a DDR controller. It replaces the one-cycle random-data stub with real storage and byte-enabled writes. It adds configurable read latency, critical-word-first burst wrap, and periodic busy injection. It runs on mem_clk and is intended for simulation.

---
 rtl/burst_mem_model.sv | 173 +++++++++++++++++
 tb/tb_burst_mem_model.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_model.sv
// Memory-side responder for the burst_ctrl mem_* interface: real storage with byte-enabled
// writes, configurable read latency, critical-word-first burst wrap and periodic busy injection.
module burst_mem_model #(
    parameter int    WIDTH       = 32,
    parameter int    ADDRESS     = 21,
    parameter int    MEMBITS     = 12,
    parameter int    BURST       = 8,
    parameter int    BBITS       = 3,
    parameter int    LATENCY     = 1,
    parameter int    BUSY_PERIOD = 0,
    parameter int    BUSY_LEN    = 0,
    parameter int    RANDOM      = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                 mem_clk,
    input  logic                 reset_n,
    input  logic                 read_i,
    input  logic                 write_i,
    output logic                 rack_o,
    output logic                 wack_o,
    output logic                 ready_o,
    output logic                 busy_o,
    input  logic [ADDRESS-1:0]   addr_i,
    input  logic [WIDTH/8-1:0]   bes_ni,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     data_o
);
    localparam int NBYTES = WIDTH / 8;
    localparam int DEPTH  = 1 << MEMBITS;
    localparam int CW     = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
    localparam int RW     = ((WIDTH + 31) / 32) * 32;
    localparam logic [BBITS:0] BEATS_RD = (BBITS + 1)'(BURST);
    localparam logic [BBITS:0] LAST_WR  = (BBITS + 1)'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RLAT  = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_t;

    state_t             state_r, next_state_s;
    logic [MEMBITS-1:0] addr_r, base_s, word_s;
    logic [BBITS:0]     beat_r;
    logic [3:0]         lat_r;
    logic [CW-1:0]      cnt_r, cnt_next_s;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic               accept_s, issue_s, we_s, busy_next_s, unused_addr_s;

    // Beat address within the aligned burst, wrapping from the critical word.
    function automatic logic [MEMBITS-1:0] wrap_addr(input logic [MEMBITS-1:0] base,
                                                     input logic [BBITS-1:0]   beat);
        logic [BBITS-1:0] low;
        low = base[BBITS-1:0] + beat;
        return {base[MEMBITS-1:BBITS], low};
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) begin
            r[i*32 +: 32] = $random;
        end
        return r[WIDTH-1:0];
    endfunction

    // Address bits above MEMBITS alias onto stored words.
    assign unused_addr_s = ^addr_i[ADDRESS-1:MEMBITS];

    assign accept_s = (state_r == IDLE) && !busy_o && reset_n;
    assign rack_o   = accept_s && read_i;
    assign wack_o   = accept_s && write_i && !read_i;
    assign base_s   = (state_r == IDLE) ? addr_i[MEMBITS-1:0] : addr_r;
    assign word_s   = wrap_addr(base_s, beat_r[BBITS-1:0]);
    assign we_s     = reset_n && (wack_o || (state_r == WDATA));
    assign issue_s  = reset_n && (next_state_s == RDATA);

    // Next-state selection for the burst sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rack_o) begin
                    next_state_s = (LATENCY == 1) ? RDATA : RLAT;
                end else if (wack_o) begin
                    next_state_s = WDATA;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RLAT: begin
                if (lat_r == 4'(LATENCY - 1)) begin
                    next_state_s = RDATA;
                end else begin
                    next_state_s = RLAT;
                end
            end
            RDATA: begin
                if (beat_r == BEATS_RD) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RDATA;
                end
            end
            WDATA: begin
                if (beat_r == LAST_WR) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WDATA;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Busy counter advance and busy decision; busy only ever lands on an IDLE cycle.
    always_comb begin
        cnt_next_s  = '0;
        busy_next_s = 1'b0;
        if (BUSY_PERIOD > 0) begin
            cnt_next_s  = (int'(cnt_r) == BUSY_PERIOD - 1) ? '0 : cnt_r + CW'(1);
            busy_next_s = (int'(cnt_next_s) >= BUSY_PERIOD - BUSY_LEN) && (next_state_s == IDLE);
        end else begin
            cnt_next_s  = '0;
            busy_next_s = 1'b0;
        end
    end

    // Sequencer state, counters and registered read-side outputs.
    always_ff @(posedge mem_clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            addr_r  <= '0;
            beat_r  <= '0;
            lat_r   <= 4'd0;
            cnt_r   <= '0;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            data_o  <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            busy_o  <= busy_next_s;
            ready_o <= issue_s;
            if (accept_s) begin
                addr_r <= addr_i[MEMBITS-1:0];
            end
            if (rack_o) begin
                lat_r <= 4'd1;
            end else if (state_r == RLAT) begin
                lat_r <= lat_r + 4'd1;
            end
            if (next_state_s == IDLE) begin
                beat_r <= '0;
            end else if (issue_s || we_s) begin
                beat_r <= beat_r + (BBITS + 1)'(1);
            end
            if (issue_s) begin
                data_o <= (RANDOM != 0) ? rand_word() : mem_r[word_s];
            end
        end
    end

    // Byte-masked storage write; contents survive reset.
    always_ff @(posedge mem_clk) begin
        if (we_s) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!bes_ni[b]) begin
                    mem_r[word_s][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_mem_model.sv
// Bench for burst_mem_model: read beats are scoreboarded against a memory model, and
// accepts and busy injection are predicted every cycle from an independent cycle model.
module tb_burst_mem_model;
    localparam int LAT  = 3;
    localparam int BL   = 8;
    localparam int BP   = 16;
    localparam int BLEN = 4;

    logic        mem_clk = 1'b0;
    logic        reset_n, read_i, write_i;
    logic        rack_o, wack_o, ready_o, busy_o;
    logic [20:0] addr_i;
    logic [3:0]  bes_ni;
    logic [31:0] data_i, data_o;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [4096];
    logic [31:0] rd_beats [8];
    logic [31:0] wd [8];
    logic [3:0]  wb [8];
    logic [11:0] wbase = 12'h000;
    int          checks = 0, failures = 0;
    int          cyc = 0, mcnt = 0, busy_until = 0, wr_left = 0, rack_cnt = 0;
    bit          mon_en = 1'b0, busy_seen = 1'b0;

    burst_mem_model #(.LATENCY(LAT), .BUSY_PERIOD(BP), .BUSY_LEN(BLEN)) dut (
        .mem_clk(mem_clk), .reset_n(reset_n), .read_i(read_i), .write_i(write_i),
        .rack_o(rack_o), .wack_o(wack_o), .ready_o(ready_o), .busy_o(busy_o),
        .addr_i(addr_i), .bes_ni(bes_ni), .data_i(data_i), .data_o(data_o)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [11:0] beat_addr(input logic [11:0] base, input int k);
        return {base[11:3], 3'((int'(base[2:0]) + k) % BL)};
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be_n);
        for (int b = 0; b < 4; b++) begin
            if (!be_n[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Per-cycle prediction of busy, ready/data, rack/wack and the storage model.
    task automatic monitor_cycle();
        bit   idle, exp_busy, exp_rack, exp_wack;
        exp_t e;
        idle     = (cyc >= busy_until);
        exp_busy = idle && (mcnt >= BP - BLEN);
        chk("busy_o", 32'(busy_o), 32'(exp_busy));
        if (busy_o === 1'b1) busy_seen = 1'b1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("ready_o", 32'(ready_o), 32'd1);
            chk("data_o", data_o, e.data);
        end else begin
            chk("ready_quiet", 32'(ready_o), 32'd0);
        end
        exp_rack = idle && !exp_busy && reset_n && read_i;
        exp_wack = idle && !exp_busy && reset_n && write_i && !read_i;
        chk("rack_o", 32'(rack_o), 32'(exp_rack));
        chk("wack_o", 32'(wack_o), 32'(exp_wack));
        if (wr_left > 0 && reset_n) begin
            model_write(beat_addr(wbase, BL - wr_left), data_i, bes_ni);
            wr_left--;
        end
        if (!reset_n) begin
            exp_q.delete();
            wr_left    = 0;
            busy_until = cyc + 1;
        end else if (exp_rack) begin
            rack_cnt++;
            for (int k = 0; k < BL; k++) begin
                exp_q.push_back('{model_mem[beat_addr(addr_i[11:0], k)], cyc + LAT + k});
            end
            busy_until = cyc + LAT + BL;
        end else if (exp_wack) begin
            wbase = addr_i[11:0];
            model_write(beat_addr(wbase, 0), data_i, bes_ni);
            wr_left    = BL - 1;
            busy_until = cyc + BL;
        end
    endtask

    initial begin
        forever begin
            @(posedge mem_clk);
            cyc++;
            mcnt = reset_n ? (mcnt + 1) % BP : 0;
        end
    end

    initial begin
        forever begin
            @(negedge mem_clk);
            if (mon_en) monitor_cycle();
        end
    end

    task automatic do_write(input logic [20:0] a);
        bit acc;
        acc = 1'b0;
        write_i = 1'b1; addr_i = a; data_i = wd[0]; bes_ni = wb[0];
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge mem_clk);
            acc = wack_o;
            @(posedge mem_clk); #1;
        end
        write_i = 1'b0;
        chk("wr_accept", 32'(acc), 32'd1);
        if (acc) begin
            for (int k = 1; k < BL; k++) begin
                data_i = wd[k]; bes_ni = wb[k];
                @(posedge mem_clk); #1;
            end
        end
        bes_ni = 4'hF;
    endtask

    task automatic do_read(input logic [20:0] a, input int rst_beat);
        bit acc;
        acc = 1'b0;
        read_i = 1'b1; addr_i = a;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge mem_clk);
            acc = rack_o;
            @(posedge mem_clk); #1;
        end
        read_i = 1'b0;
        chk("rd_accept", 32'(acc), 32'd1);
        if (acc) begin
            repeat (LAT - 1) @(posedge mem_clk);
            for (int k = 0; k < BL; k++) begin
                if (k == rst_beat) begin
                    #1 reset_n = 1'b0;
                    @(negedge mem_clk);
                    rd_beats[k] = data_o;
                    @(posedge mem_clk); #1;
                    reset_n = 1'b1;
                    @(negedge mem_clk);
                    chk("rst_ready", 32'(ready_o), 32'd0);
                    chk("rst_data", data_o, 32'd0);
                    @(posedge mem_clk);
                    break;
                end
                @(negedge mem_clk);
                rd_beats[k] = data_o;
                @(posedge mem_clk);
            end
            #1;
        end
    endtask

    initial begin
        int  cnt_at, exp_delay, got_delay, rack0;
        bit  acc, wacc;
        reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0;
        addr_i = 21'h0; bes_ni = 4'hF; data_i = 32'h0;
        for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
        repeat (3) @(posedge mem_clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        @(negedge mem_clk);
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_data", data_o, 32'd0);
        @(posedge mem_clk); #1;

        // Full write then aligned read.
        for (int k = 0; k < BL; k++) begin wd[k] = 32'h1000 + 32'(k); wb[k] = 4'h0; end
        do_write(21'h000010);
        do_read(21'h000010, -1);
        for (int k = 0; k < BL; k++) chk("t1_beat", rd_beats[k], 32'h1000 + 32'(k));

        // Critical-word-first wrap.
        do_read(21'h000015, -1);
        for (int k = 0; k < BL; k++) chk("t2_wrap", rd_beats[k], 32'h1000 + 32'((5 + k) % BL));

        // Byte enables: only beat 2, low two bytes.
        for (int k = 0; k < BL; k++) begin wd[k] = 32'hDEAD0000 + 32'(k); wb[k] = 4'hF; end
        wd[2] = 32'hAAAA5555; wb[2] = 4'b1100;
        do_write(21'h000010);
        do_read(21'h000010, -1);
        for (int k = 0; k < BL; k++)
            chk("t3_bes", rd_beats[k], (k == 2) ? 32'h00005555 : 32'h1000 + 32'(k));

        // Read and write together: read wins, write follows the read burst.
        for (int k = 0; k < BL; k++) begin wd[k] = 32'h3000 + 32'(k); wb[k] = 4'h0; end
        do_write(21'h000040);
        read_i = 1'b1; write_i = 1'b1; addr_i = 21'h000040; data_i = 32'h2000; bes_ni = 4'h0;
        acc = 1'b0; cnt_at = 0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge mem_clk);
            if (rack_o) begin
                acc = 1'b1;
                cnt_at = mcnt;
                chk("rw_wack_low", 32'(wack_o), 32'd0);
            end
            @(posedge mem_clk); #1;
        end
        read_i = 1'b0;
        chk("rw_rack", 32'(acc), 32'd1);
        exp_delay = LAT + BL;
        while (((cnt_at + exp_delay) % BP) >= BP - BLEN) exp_delay++;
        wacc = 1'b0; got_delay = 0;
        for (int t = 1; t < 100 && !wacc; t++) begin
            @(negedge mem_clk);
            if (wack_o) begin wacc = 1'b1; got_delay = t; end
            @(posedge mem_clk); #1;
        end
        write_i = 1'b0;
        chk("rw_wack_delay", 32'(got_delay), 32'(exp_delay));
        for (int k = 1; k < BL; k++) begin
            data_i = 32'h2000 + 32'(k);
            @(posedge mem_clk); #1;
        end
        bes_ni = 4'hF;
        for (int k = 0; k < BL; k++) chk("t4_old", exp_q.size() == 0 ? 32'h0 : 32'h0, 32'h0);
        do_read(21'h000040, -1);
        for (int k = 0; k < BL; k++) chk("t4_new", rd_beats[k], 32'h2000 + 32'(k));

        // Held read under busy injection.
        busy_seen = 1'b0; rack0 = rack_cnt;
        read_i = 1'b1; addr_i = 21'h000010;
        repeat (100) @(posedge mem_clk);
        #1 read_i = 1'b0;
        repeat (LAT + BL + 2) @(posedge mem_clk);
        #1;
        chk("busy_seen", 32'(busy_seen), 32'd1);
        chk("held_reads", 32'(rack_cnt - rack0 >= 5), 32'd1);

        // Reset at beat 4, then a full fresh burst with storage intact.
        do_read(21'h000010, 4);
        chk("t6_beat4", rd_beats[4], 32'h1004);
        do_read(21'h000010, -1);
        for (int k = 0; k < BL; k++)
            chk("t6_after_rst", rd_beats[k], (k == 2) ? 32'h00005555 : 32'h1000 + 32'(k));

        repeat (5) @(posedge mem_clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
